// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - pipelined MIPS main control, load-use stall, fetch flush; optional forwarding via CTRL_PIPE_FWD_EN
module ctrl_pipe #(
  parameter int OPC_W  = 6,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [OPC_W-1:0]  id_opcode,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              if_flush,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [REG_W-1:0]  ex_dst,
  output logic [REG_W-1:0]  mem_dst,
  output logic [REG_W-1:0]  wb_dst
`ifdef CTRL_PIPE_FWD_EN
  ,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`endif
);

  localparam logic [OPC_W-1:0] OP_R   = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_J   = OPC_W'(6'b000010);
  localparam logic [OPC_W-1:0] OP_BEQ = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0] OP_LW  = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OP_LH  = OPC_W'(6'b100001);
  localparam logic [OPC_W-1:0] OP_LB  = OPC_W'(6'b100000);
  localparam logic [OPC_W-1:0] OP_SW  = OPC_W'(6'b101011);
  localparam logic [OPC_W-1:0] OP_SH  = OPC_W'(6'b101001);
  localparam logic [OPC_W-1:0] OP_SB  = OPC_W'(6'b101000);

  logic [10:0]      dec_base;
  logic [10:0]      dec_word;
  logic [REG_W-1:0] id_dst;
  logic             uses_rt;
  logic             is_jump;
  logic             hazard;
  logic             taken;
  logic             ex_load;

  // Opcode to raw 11-bit control word; unknown opcodes become a no-destination nop
  always_comb begin
    dec_base = 11'h008;
    case (id_opcode)
      OP_R:    dec_base = 11'h003;
      OP_J:    dec_base = 11'h400;
      OP_BEQ:  dec_base = 11'h200;
      OP_LW:   dec_base = 11'h146;
      OP_LH:   dec_base = 11'h156;
      OP_LB:   dec_base = 11'h166;
      OP_SW:   dec_base = 11'h084;
      OP_SH:   dec_base = 11'h094;
      OP_SB:   dec_base = 11'h0A4;
      default: dec_base = 11'h008;
    endcase
  end

  // Pick destination and demote writes to r0 into nop_dst so later stages never forward or hazard on r0
  always_comb begin
    dec_word = dec_base;
    id_dst   = dec_base[0] ? id_rd : id_rt;
    if (dec_base[1] && (id_dst == '0)) begin
      dec_word[1] = 1'b0;
      dec_word[3] = 1'b1;
    end
  end

  // rt is a source operand only for R-type, beq and stores; loads write it instead
  assign uses_rt = (id_opcode == OP_R) || (id_opcode == OP_BEQ) ||
                   (id_opcode == OP_SW) || (id_opcode == OP_SH) || (id_opcode == OP_SB);
  assign is_jump = id_valid && (id_opcode == OP_J);

  assign taken  = ex_valid && ex_ctrl[9] && ex_branch_taken;
  assign hazard = ex_valid && ex_ctrl[8] && (ex_dst != '0) && id_valid &&
                  ((ex_dst == id_rs) || ((ex_dst == id_rt) && uses_rt));

  // A taken branch squashes ID, so a hazard against the squashed instruction is moot
  assign stall    = hazard && !taken;
  assign if_flush = taken || (is_jump && !stall);
  assign ex_load  = id_valid && !stall && !taken;

  // ID/EX register: take the decoded instruction or insert a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl  <= '0;
      ex_valid <= 1'b0;
      ex_dst   <= '0;
    end else if (ex_load) begin
      ex_ctrl  <= CTRL_W'(dec_word);
      ex_valid <= 1'b1;
      ex_dst   <= id_dst;
    end else begin
      ex_ctrl  <= '0;
      ex_valid <= 1'b0;
      ex_dst   <= '0;
    end
  end

  // EX/MEM and MEM/WB registers advance every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ctrl  <= '0;
      mem_valid <= 1'b0;
      mem_dst   <= '0;
      wb_ctrl   <= '0;
      wb_valid  <= 1'b0;
      wb_dst    <= '0;
    end else begin
      mem_ctrl  <= ex_ctrl;
      mem_valid <= ex_valid;
      mem_dst   <= ex_dst;
      wb_ctrl   <= mem_ctrl;
      wb_valid  <= mem_valid;
      wb_dst    <= mem_dst;
    end
  end

`ifdef CTRL_PIPE_FWD_EN
  logic [REG_W-1:0] ex_rs;
  logic [REG_W-1:0] ex_rt;

  // EX-stage source registers follow the same load/bubble rule as the control word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs <= '0;
      ex_rt <= '0;
    end else if (ex_load) begin
      ex_rs <= id_rs;
      ex_rt <= id_rt;
    end else begin
      ex_rs <= '0;
      ex_rt <= '0;
    end
  end

  // Forward select per operand; the younger MEM result wins over WB
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_rs != '0) begin
      if (mem_valid && mem_ctrl[1] && (mem_dst == ex_rs))   fwd_a = 2'b10;
      else if (wb_valid && wb_ctrl[1] && (wb_dst == ex_rs)) fwd_a = 2'b01;
    end
    if (ex_rt != '0) begin
      if (mem_valid && mem_ctrl[1] && (mem_dst == ex_rt))   fwd_b = 2'b10;
      else if (wb_valid && wb_ctrl[1] && (wb_dst == ex_rt)) fwd_b = 2'b01;
    end
  end
`endif

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined main-control unit for the 5-stage MIPS core. Decodes the ID-stage opcode into an 11-bit control word and carries it through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards, which stall ID and insert an EX bubble.
- Generates fetch flush on jumps and taken branches.
- Sits between the IF/ID register and the datapath stage muxes.

Parameters:
- OPC_W, 6, opcode width.
- REG_W, 5, register-address width. Register 0 is the hard-wired zero register.
- CTRL_W, 11, control-word width. Fixed layout below; values above 11 zero-pad the MSBs.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode  in  OPC_W  instruction[31:26].
- id_rs  in  REG_W  source register.
- id_rt  in  REG_W  target register.
- id_rd  in  REG_W  destination register.
- ex_branch_taken  in  1  EX comparator result for the instruction in EX.
- stall  out  1  hold PC and IF/ID (combinational).
- if_flush  out  1  squash IF/ID on the next edge (combinational).
- ex_ctrl  out  CTRL_W  EX-stage control word.
- mem_ctrl  out  CTRL_W  MEM-stage control word.
- wb_ctrl  out  CTRL_W  WB-stage control word.
- ex_valid, mem_valid, wb_valid  out  1 each  stage occupancy.
- ex_dst, mem_dst, wb_dst  out  REG_W each  destination register per stage.
- fwd_a, fwd_b  out  2 each  forwarding selects; present only with the optional feature.

Behaviour:
- Control word layout:
  - [10] jump, [9] branch, [8] mem_read, [7] mem_write, [6] mem_to_reg
  - [5:4] size (00 word, 01 half, 10 byte)
  - [3] nop_dst, [2] alu_src, [1] reg_write, [0] reg_dst
- Decode (combinational, ID stage):
  - R 000000: 0x003
  - J 000010: 0x400
  - beq 000100: 0x200
  - lw 100011: 0x146; lh 100001: 0x156; lb 100000: 0x166
  - sw 101011: 0x084; sh 101001: 0x094; sb 101000: 0x0A4
  - Any other opcode: 0x008
- Destination and nop_dst:
  - Destination = reg_dst ? id_rd : id_rt.
  - If reg_write=1 and destination==0: clear reg_write, set nop_dst. Examples: R with rd=0 gives 0x009; lw with rt=0 gives 0x14C.
- Load-use stall: stall=1 when all of the following hold:
  - ex_valid and ex_ctrl[8]
  - ex_dst!=0
  - id_valid
  - ex_dst==id_rs, or (ex_dst==id_rt and the ID instruction is R, beq or store)
- Branch flush: taken = ex_valid & ex_ctrl[9] & ex_branch_taken. When taken:
  - if_flush=1
  - the ID instruction is squashed
  - stall is forced to 0
- Jump flush: if ID decodes J with id_valid=1 and there is no stall, then if_flush=1. The jump itself advances to EX.
- Priority: branch flush > stall > jump > normal.
- Each edge, EX register update:
  - Loads the decoded word, valid and dst when id_valid, no stall and no branch flush.
  - Otherwise loads a bubble: ctrl=0, valid=0, dst=0.
- MEM and WB registers advance unconditionally (EX to MEM, MEM to WB). Latency from ID to WB outputs is 3 cycles.
- Reset (asynchronous, any time, including mid-stall):
  - All ctrl=0, valid=0, dst=0; stall=0, if_flush=0.
  - The pipeline restarts empty on the first edge after release.
- Bubbles never assert stall or flush. id_valid=0 inserts a bubble without stall.

Optional Feature:
- Macro: CTRL_PIPE_FWD_EN.
- With the macro defined, fwd_a and fwd_b are driven combinationally for the EX operands (rs and rt held in EX-stage registers):
  - 10: MEM forward, when mem_valid, mem_ctrl[1] and mem_dst==operand, with operand!=0.
  - 01: WB forward, same conditions against WB.
  - 00: otherwise.
  - MEM has priority over WB.
- Without the macro, the ports and the rs/rt EX registers are absent; the datapath stalls externally.

Test Plan:
- Reset with rst_n low, then release, then 4 idle cycles -> all ctrl=0x000, all valid=0, stall=0, if_flush=0.
- R opcode 000000 with rd=7, then lw 100011 with rt=3, then sw 101011 -> ex_ctrl shows 0x003, 0x146, 0x084 on consecutive cycles; wb_ctrl shows 0x003 three cycles after the R instruction; ex_dst=7 then 3.
- lw with rt=5, followed by R with rs=5 -> stall=1 for exactly 1 cycle; EX holds a bubble (0x000); the R instruction reaches EX (0x003) one cycle later.
- beq in EX with ex_branch_taken=1 while ID holds a load-use-hazard instruction -> if_flush=1, stall=0, next ex_ctrl=0x000.
- Opcode 111111, then R with rd=0, then J -> ex_ctrl 0x008, 0x009, 0x400; if_flush=1 while J is in ID.
- With CTRL_PIPE_FWD_EN: R to r4, then R reading r4 in rs, plus an older R to r4 in WB -> fwd_a=10 (MEM priority). Repeat with dst=0 -> fwd_a=00.
